// File: rtl/motion_seg_sched.sv
// rtl/motion_seg_sched.sv - segment FIFO and load sequencer for acc_step_gen
// Queues (dt, steps) segments and hands them to the step generator back-to-back.
module motion_seg_sched #(
  parameter int DEPTH_LOG2 = 2,
  parameter int W          = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          wr_dt,
  input  logic [W-1:0]          wr_steps,
  input  logic                  wr_en,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  clear_err,
  input  logic                  gen_done,
  input  logic                  gen_stopped,
  output logic [W-1:0]          gen_dt_val,
  output logic [W-1:0]          gen_steps_val,
  output logic                  gen_load,
  output logic                  gen_abort,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  busy,
  output logic                  underrun,
  output logic                  wr_err,
  output logic [15:0]           seg_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]          mem_dt    [DEPTH];
  logic [W-1:0]          mem_steps [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic push;
  logic pop;
  logic start_acc;
  logic underrun_set;
  logic wr_err_set;
  logic queue_empty;

  // Status only; the sequencer never reacts to the generator's stopped flag.
  logic unused_gen_stopped;
  assign unused_gen_stopped = gen_stopped;

  assign full        = (level == FULL_LEVEL);
  assign busy        = (state != IDLE);
  assign queue_empty = (level == '0);

  // Full is judged on the registered level, so a pop in the same cycle never rescues a write.
  assign push         = wr_en && !full && !abort;
  assign pop          = (state == LOAD) && !abort;
  assign wr_err_set   = wr_en && full;
  assign start_acc    = (state == IDLE) && start && !queue_empty && !abort;
  assign underrun_set = (state == RUN) && gen_done && queue_empty && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !queue_empty) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (gen_done) state_nxt = queue_empty ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dt[wr_ptr]    <= wr_dt;
      mem_steps[wr_ptr] <= wr_steps;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_dt_val    <= '0;
      gen_steps_val <= '0;
      gen_load      <= 1'b0;
      gen_abort     <= 1'b0;
      seg_count     <= '0;
    end else begin
      gen_load  <= pop;
      gen_abort <= abort;
      if (pop) begin
        gen_dt_val    <= mem_dt[rd_ptr];
        gen_steps_val <= mem_steps[rd_ptr];
      end
      if (start_acc) begin
        seg_count <= '0;
      end else if (pop) begin
        seg_count <= seg_count + 16'd1;
      end
    end
  end

  // A set event in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      underrun <= underrun_set | (underrun & ~clear_err);
      wr_err   <= wr_err_set   | (wr_err   & ~clear_err);
    end
  end

endmodule

// File: tb/tb_motion_seg_sched.sv
// tb/tb_motion_seg_sched.sv - scoreboard bench for motion_seg_sched
// Loads are checked by a negedge monitor against a queue of expected (dt, steps, cycle).
module tb_motion_seg_sched;

  logic        clk;
  logic        reset;
  logic [31:0] wr_dt;
  logic [31:0] wr_steps;
  logic        wr_en;
  logic        start;
  logic        abort;
  logic        clear_err;
  logic        gen_done;
  logic        gen_stopped;
  logic [31:0] gen_dt_val;
  logic [31:0] gen_steps_val;
  logic        gen_load;
  logic        gen_abort;
  logic [2:0]  level;
  logic        full;
  logic        busy;
  logic        underrun;
  logic        wr_err;
  logic [15:0] seg_count;

  motion_seg_sched #(.DEPTH_LOG2(2), .W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_dt         (wr_dt),
    .wr_steps      (wr_steps),
    .wr_en         (wr_en),
    .start         (start),
    .abort         (abort),
    .clear_err     (clear_err),
    .gen_done      (gen_done),
    .gen_stopped   (gen_stopped),
    .gen_dt_val    (gen_dt_val),
    .gen_steps_val (gen_steps_val),
    .gen_load      (gen_load),
    .gen_abort     (gen_abort),
    .level         (level),
    .full          (full),
    .busy          (busy),
    .underrun      (underrun),
    .wr_err        (wr_err),
    .seg_count     (seg_count)
  );

  typedef struct {
    logic [31:0] dt;
    logic [31:0] steps;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset && gen_load) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_gen_load: got load at cycle %0d, expected none", cyc_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("load_dt", gen_dt_val, e.dt);
        chk("load_steps", gen_steps_val, e.steps);
        chk("load_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [31:0] dt, input logic [31:0] st);
    wr_dt    = dt;
    wr_steps = st;
    wr_en    = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic expect_load(input logic [31:0] dt, input logic [31:0] st);
    exp_t e;
    e.dt    = dt;
    e.steps = st;
    e.cyc   = cyc_cnt + 2;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_done();
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    wr_dt = 32'd0; wr_steps = 32'd0; wr_en = 1'b0;
    start = 1'b0; abort = 1'b0; clear_err = 1'b0;
    gen_done = 1'b0; gen_stopped = 1'b0;

    // Reset held with activity on the write/start inputs
    for (int i = 0; i < 3; i++) begin
      wr_en = i[0] ? 1'b0 : 1'b1;
      start = i[0];
      wr_dt = 32'd99;
      step();
    end
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gen_load", 32'(gen_load), 32'd0);
    chk("rst_gen_abort", 32'(gen_abort), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_seg_count", 32'(seg_count), 32'd0);
    chk("rst_dt", gen_dt_val, 32'd0);
    chk("rst_steps", gen_steps_val, 32'd0);
    wr_en = 1'b0; start = 1'b0;
    reset = 1'b1;
    step();

    // Single segment, then underrun on its done
    write(32'd20, 32'd20);
    chk("single_level", 32'(level), 32'd1);
    expect_load(32'd20, 32'd20);
    do_start();
    chk("single_busy", 32'(busy), 32'd1);
    step();
    chk("single_seg_count", 32'(seg_count), 32'd1);
    chk("single_level_after", 32'(level), 32'd0);
    steps(2);
    gen_stopped = 1'b1;
    do_done();
    gen_stopped = 1'b0;
    chk("single_underrun", 32'(underrun), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_hold_dt", gen_dt_val, 32'd20);

    // Back-to-back three segments
    do_clear();
    chk("clr_underrun", 32'(underrun), 32'd0);
    write(32'd20, 32'd20);
    write(32'd10, 32'd5);
    write(32'd40, 32'd3);
    expect_load(32'd20, 32'd20);
    do_start();
    steps(4);
    expect_load(32'd10, 32'd5);
    do_done();
    steps(4);
    expect_load(32'd40, 32'd3);
    do_done();
    steps(4);
    chk("b2b_underrun_pre", 32'(underrun), 32'd0);
    do_done();
    chk("b2b_seg_count", 32'(seg_count), 32'd3);
    chk("b2b_underrun", 32'(underrun), 32'd1);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Fill to capacity and overflow
    do_clear();
    for (int i = 1; i <= 4; i++) write(32'(i * 100), 32'(i));
    chk("full_flag", 32'(full), 32'd1);
    chk("full_level", 32'(level), 32'd4);
    chk("full_wr_err_pre", 32'(wr_err), 32'd0);
    write(32'd500, 32'd5);
    chk("ovf_wr_err", 32'(wr_err), 32'd1);
    chk("ovf_level", 32'(level), 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("flush_gen_abort", 32'(gen_abort), 32'd1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_wr_err_kept", 32'(wr_err), 32'd1);
    step();
    chk("flush_gen_abort_end", 32'(gen_abort), 32'd0);
    do_clear();
    chk("clr_wr_err", 32'(wr_err), 32'd0);

    // Abort during the first segment
    write(32'd1, 32'd2);
    write(32'd3, 32'd4);
    write(32'd5, 32'd6);
    expect_load(32'd1, 32'd2);
    do_start();
    steps(3);
    chk("abort_running", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_gen_abort", 32'(gen_abort), 32'd1);
    chk("abort_level", 32'(level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    steps(2);
    do_done();
    steps(4);
    chk("abort_hold_dt", gen_dt_val, 32'd1);
    chk("abort_underrun", 32'(underrun), 32'd0);

    // Start with an empty queue is ignored
    do_start();
    chk("empty_start_busy", 32'(busy), 32'd0);
    chk("empty_start_seg", 32'(seg_count), 32'd1);

    // Push during the LOAD cycle pops and pushes together
    write(32'd7, 32'd8);
    write(32'd9, 32'd10);
    expect_load(32'd7, 32'd8);
    do_start();
    chk("pp_level_load", 32'(level), 32'd2);
    write(32'd11, 32'd12);
    chk("pp_level_same", 32'(level), 32'd2);
    steps(2);
    expect_load(32'd9, 32'd10);
    do_done();
    steps(4);
    expect_load(32'd11, 32'd12);
    do_done();
    steps(4);
    do_done();
    chk("pp_seg_count", 32'(seg_count), 32'd3);
    chk("pp_underrun", 32'(underrun), 32'd1);
    steps(4);

    chk("pending_loads", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_seg_sched.md
# motion_seg_sched

Segment scheduler for the `acc_step_gen` step generator in the motion core. Buffers host-written (dt, steps) motion segments in a small FIFO and feeds them to the generator back-to-back: it loads the next segment on each `done`, detects queue underrun, and supports start/abort control. Sits between the bus register interface and one `acc_step_gen` instance.

## Interface
- `DEPTH_LOG2`, 2, log2 of FIFO depth (default 4 entries)
- `W`, 32, width of dt and steps fields
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `wr_dt`  in  W  segment dt value to enqueue
- `wr_steps`  in  W  segment step count to enqueue
- `wr_en`  in  1  enqueue strobe, one entry per cycle high
- `start`  in  1  begin executing queued segments (pulse)
- `abort`  in  1  stop immediately and flush queue (pulse)
- `clear_err`  in  1  clears sticky `underrun` and `wr_err`
- `gen_done`  in  1  from `acc_step_gen.done`, one-cycle pulse at segment end
- `gen_stopped`  in  1  from `acc_step_gen.stopped`
- `gen_dt_val`  out  W  to `acc_step_gen.dt_val`, registered
- `gen_steps_val`  out  W  to `acc_step_gen.steps_val`, registered
- `gen_load`  out  1  to `acc_step_gen.load`, one-cycle pulse
- `gen_abort`  out  1  one-cycle pulse, ORed into the generator's active-high reset
- `level`  out  DEPTH_LOG2+1  FIFO occupancy
- `full`  out  1  level == 2^DEPTH_LOG2
- `busy`  out  1  state != IDLE
- `underrun`  out  1  sticky: `gen_done` with empty queue while running
- `wr_err`  out  1  sticky: `wr_en` while full
- `seg_count`  out  16  segments loaded since last accepted `start`, wraps at 0xFFFF

## Operation
- FIFO: 2^DEPTH_LOG2 entries of {dt, steps}, circular read/write pointers, `level` counter.
- Write: `wr_en` && !`full` pushes. `wr_en` && `full` drops the write and sets `wr_err`, even if a pop happens in the same cycle (full is evaluated before the pop). Push and pop in the same non-full cycle: `level` unchanged.
- FSM states IDLE, LOAD, RUN:
  - IDLE: `start` && level>0 -> LOAD, clears `seg_count`. `start` with level 0 is ignored.
  - LOAD: (one cycle) registers FIFO head into `gen_dt_val`/`gen_steps_val`, pops, and increments `seg_count`. -> RUN. `gen_load` is high in the following cycle, coincident with the new values.
  - RUN: on `gen_done`, level>0 -> LOAD; level==0 -> sets `underrun` -> IDLE. Otherwise stay.
- `abort` (any state, highest priority): -> IDLE, pointers and `level` cleared, `gen_load` suppressed, `gen_abort` pulsed next cycle. Writes in the abort cycle are discarded. Sticky flags are kept.
- `clear_err` clears both sticky flags. A set event in the same cycle wins.
- Values on `gen_dt_val`/`gen_steps_val` hold between loads.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty. `full`=0 and `level`=0.
- `start` at cycle N (queue non-empty): LOAD at N+1, `gen_load` high at N+2 with valid values.
- `gen_done` at cycle M with queue non-empty: LOAD at M+1, `gen_load` at M+2. The inter-segment gap is 2 cycles, fixed.
- `level` and `full` update the cycle after the push/pop edge.
- Reset assertion mid-run: immediate return to reset values. No `gen_abort` pulse (the generator shares the system reset).
- `seg_count` 0xFFFF + 1 -> 0x0000, no flag.
- `gen_stopped` is only reported. It never alters FSM flow.

## Test plan
- Reset: hold `reset`=0 for 3 cycles while toggling `wr_en`/`start` -> all outputs 0, `level`=0.
- Single segment: write dt=20 steps=20, `start` -> `gen_load` exactly 2 cycles after `start`, with `gen_dt_val`=20 and `gen_steps_val`=20. `seg_count`=1. The generator's `done` -> `underrun`=1, `busy`=0.
- Back-to-back: queue (20,20),(10,5),(40,3), `start` -> three `gen_load` pulses, each 2 cycles after the preceding `done`, values in order. `seg_count`=3. Final `underrun`=1.
- Full/overflow: 5 writes with DEPTH_LOG2=2 -> `full`=1 after the 4th, 5th dropped, `wr_err`=1, `level`=4. `clear_err` -> `wr_err`=0.
- Abort mid-run: 3 queued, `start`, `abort` during first segment -> `gen_abort` pulse next cycle, `level`=0, `busy`=0, no further `gen_load`.
- Start on empty queue plus simultaneous push/pop: `start` with `level`=0 -> stays IDLE. In RUN, `wr_en` on the LOAD cycle with `level`=2 -> `level` stays 2.
